// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared constants and state encoding for the nibble-serial subtractor.
//   WIDTH  : operand/result width
//   SLICE  : bits subtracted per clock
//   NSLICE : number of slices per operation
package nibble_serial_subtractor_pkg;

  localparam int WIDTH  = 16;
  localparam int SLICE  = 4;
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  // 2'd3 is unused; the FSM falls back to IDLE if it ever appears.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_serial_subtractor_if.sv
// Operand/result handshake bundle for the nibble-serial subtractor.
//   master : producer/consumer side (drives operands, in_valid, out_ready)
//   slave  : subtractor side (drives in_ready, diff, b_out_final, out_valid)
interface nibble_serial_subtractor_if;
  import nibble_serial_subtractor_pkg::*;

  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              b_in;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  diff;
  logic [NSLICE-1:0] b_out_final;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output a, b, b_in, in_valid, out_ready,
    input  in_ready, diff, b_out_final, out_valid
  );

  modport slave (
    input  a, b, b_in, in_valid, out_ready,
    output in_ready, diff, b_out_final, out_valid
  );

endinterface

// File: rtl/nibble_serial_subtractor_sub4.sv
// Combinational SLICE-bit subtract slice: {bout, d4} = a4 - b4 - bin.
//   a4, b4 : slice operands
//   bin    : borrow into the slice
//   d4     : slice difference
//   bout   : borrow out of the slice
module nibble_sub4
  import nibble_serial_subtractor_pkg::*;
(
  input  logic [SLICE-1:0] a4,
  input  logic [SLICE-1:0] b4,
  input  logic             bin,
  output logic [SLICE-1:0] d4,
  output logic             bout
);

  logic [SLICE:0] full;

  // One extra bit catches the borrow as the sign of the widened result.
  assign full = {1'b0, a4} - {1'b0, b4} - {{SLICE{1'b0}}, bin};
  assign d4   = full[SLICE-1:0];
  assign bout = full[SLICE];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Sequential WIDTH-bit subtractor, one SLICE per clock, LSB slice first.
//   clk_i : clock, rising edge
//   rst_i : synchronous reset, active-high
//   bus   : slave side of the operand/result handshake
// State | meaning
//   IDLE  | waiting for operands, in_ready=1
//   RUN   | subtracting slice idx_q this cycle
//   DONE  | result held until out_ready
module nibble_serial_subtractor
  import nibble_serial_subtractor_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  nibble_serial_subtractor_if.slave bus
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              borrow_q, borrow_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic [NSLICE-1:0] bout_q, bout_d;

  logic [SLICE-1:0]  a4, b4, d4;
  logic              slice_bout;

  // Single slice shared across all positions, selected by idx_q.
  assign a4 = a_q[idx_q*SLICE +: SLICE];
  assign b4 = b_q[idx_q*SLICE +: SLICE];

  nibble_sub4 u_slice (
    .a4   (a4),
    .b4   (b4),
    .bin  (borrow_q),
    .d4   (d4),
    .bout (slice_bout)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_d      = bus.a;
          b_d      = bus.b;
          borrow_d = bus.b_in;
          idx_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        diff_d[idx_q*SLICE +: SLICE] = d4;
        bout_d[idx_q]                = slice_bout;
        borrow_d                     = slice_bout;
        idx_d                        = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NSLICE - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      bout_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end

  assign bus.in_ready    = (state_q == ST_IDLE);
  assign bus.out_valid   = (state_q == ST_DONE);
  assign bus.diff        = diff_q;
  assign bus.b_out_final = bout_q;

endmodule

// File: doc/nibble_serial_subtractor.md
Name: nibble_serial_subtractor

Overview:
- Sequential 16-bit subtractor; the inverse of the nibble-chained ripple adder.
- Computes diff = a - b - bIn one 4-bit slice per clock, LSB nibble first, rippling the borrow through a registered borrow flop.
- Sits beside the adder in the datapath. Operands enter through a valid/ready handshake and results leave through one.
- Exposes per-nibble borrow-outs, mirroring the adder's per-nibble carry-outs.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of SLICE.
- SLICE, 4, bits processed per cycle; NSLICE = WIDTH/SLICE (default 4).

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Rst  in  1  synchronous reset, active-high.
- a  in  WIDTH  minuend, sampled on accept.
- b  in  WIDTH  subtrahend, sampled on accept.
- bIn  in  1  borrow-in, sampled on accept.
- inValid  in  1  operands valid.
- inReady  out  1  block can accept operands.
- diff  out  WIDTH  result, (a - b - bIn) mod 2^WIDTH.
- bOutFinal  out  NSLICE  borrow-out of each nibble; bit NSLICE-1 = overall borrow.
- outValid  out  1  diff/bOutFinal valid.
- outReady  in  1  consumer accepts result.

Behaviour:
- Reset: Rst high at an edge forces state IDLE, diff=0, bOutFinal=0, outValid=0, borrow reg=0, slice index=0. inReady=1 from the first cycle after reset.
- Reset mid-operation abandons the operation; no outValid is produced for it.
- States: IDLE, RUN, DONE. inReady = (state==IDLE); outValid = (state==DONE); both decoded from registered state.
- IDLE: accept when inValid && inReady at an edge (E0). Capture a, b, and bIn into the borrow reg. Clear index. Go to RUN.
- RUN: each edge, slice k = index computes {bout, d} = a[k] - b[k] - borrow. Write d to diff[k], write bout to bOutFinal[k] and the borrow reg, then increment index.
- Slice k is registered at edge E(k+1). After slice NSLICE-1 (E4 by default), go to DONE.
- Latency: outValid first high in the cycle following E4, i.e. 4 edges after accept.
- DONE: diff and bOutFinal hold stable while outReady is low, with no timeout. When outReady is high at an edge, go to IDLE.
- No new accept occurs in DONE. Best-case throughput is one op per NSLICE+2 cycles.
- Between accept and completion, changes on a/b/bIn/inValid have no effect. inValid while not in IDLE is ignored and not queued.
- Arithmetic: bOutFinal[NSLICE-1] = 1 iff a < b + bIn (unsigned).
- All-ones underflow wraps modulo 2^WIDTH.
- bIn=1 with a=b gives diff = all-ones and bOutFinal = all-ones.
- diff nibbles not yet written in RUN hold their previous values. Only DONE values are meaningful.
- Simultaneous Rst and handshake: Rst wins.

Decomposition:
- Shared package holds:
  - WIDTH, SLICE, NSLICE constants.
  - State encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2. 2'd3 is illegal and recovers to IDLE.
- One natural sub-module: nibble_sub4, combinational SLICE-bit subtract slice (a4, b4, bin -> d4, bout). It is instantiated once and muxed by the slice index, the counterpart of the adder's 4-bit slice.

Test Plan:
- a=0x0000, b=0x0000, bIn=0 -> diff=0x0000, bOutFinal=4'b0000; outValid rises exactly 4 edges after accept.
- a=0xCBA9, b=0x8765, bIn=0 -> diff=0x4444, bOutFinal=4'b0000.
- a=0x0000, b=0x0001, bIn=0 -> diff=0xFFFF, bOutFinal=4'b1111. Also a=0x1000, b=0x0001, bIn=1 -> diff=0x0FFE, bOutFinal=4'b0111.
- Backpressure: complete an op with outReady=0 for 10 cycles while driving inValid=1 with new operands. Required:
  - diff/bOutFinal/outValid held and inReady=0 throughout.
  - When outReady=1, IDLE follows on the next edge.
  - Only then are the new operands accepted.
- Reset mid-RUN, asserting Rst after E2 -> next cycle outValid=0, inReady=1, diff=0x0000, bOutFinal=0. A following op a=0xFFFF, b=0xFFFF, bIn=0 gives diff=0x0000, bOutFinal=0.
- Random regression: 1000 ops with random a/b/bIn and random outReady/inValid gaps -> every result matches (a-b-bIn) mod 2^16 and the golden per-nibble borrow chain.
